// File: rtl/stats_collect.sv
// stats_collect: per-channel saturating counters flushed round-robin onto an AXI-stream port.
// Define STATS_COLLECT_UPDATE_TIMER_EN to build the periodic flush timer (period UPDATE_PERIOD).
module stats_collect #(
  parameter int COUNT = 8,
  parameter int INC_WIDTH = 8,
  parameter int ID_BASE = 0,
  parameter int UPDATE_PERIOD = 1024,
  parameter int STAT_INC_WIDTH = 16,
  parameter int STAT_ID_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [COUNT*INC_WIDTH-1:0] stat_inc,
  input  logic [COUNT-1:0] stat_valid,
  input  logic update,
  output logic [STAT_INC_WIDTH-1:0] m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0] m_axis_stat_tid,
  output logic m_axis_stat_tvalid,
  input  logic m_axis_stat_tready
);
  localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1;
  logic [STAT_INC_WIDTH-1:0] acc [COUNT];
  logic [STAT_INC_WIDTH-1:0] inc [COUNT];
  logic [STAT_INC_WIDTH-1:0] sum [COUNT];
  logic [COUNT-1:0] flag;
  logic [IW-1:0] idx;
  logic [STAT_INC_WIDTH-1:0] cur;
  logic free, elig, tick, flush;
  function automatic logic [STAT_INC_WIDTH-1:0] sat_add(input logic [STAT_INC_WIDTH-1:0] a, input logic [STAT_INC_WIDTH-1:0] b);
    logic [STAT_INC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_INC_WIDTH] ? '1 : s[STAT_INC_WIDTH-1:0];
  endfunction
  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      inc[i] = stat_valid[i] ? STAT_INC_WIDTH'(stat_inc[i*INC_WIDTH +: INC_WIDTH]) : '0;
      sum[i] = sat_add(acc[i], inc[i]);
    end
  end
  assign cur = acc[idx];
  assign free = !m_axis_stat_tvalid || m_axis_stat_tready;
  assign elig = |cur && (cur[STAT_INC_WIDTH-1] || flag[idx]);
  assign flush = update || tick;
`ifdef STATS_COLLECT_UPDATE_TIMER_EN
  if (UPDATE_PERIOD > 0) begin : g_timer
    localparam int TW = UPDATE_PERIOD > 1 ? $clog2(UPDATE_PERIOD) : 1;
    logic [TW-1:0] timer;
    assign tick = timer == TW'(UPDATE_PERIOD - 1);
    always_ff @(posedge clk) timer <= rst || tick ? '0 : timer + TW'(1);
  end else begin : g_no_timer
    assign tick = 1'b0;
  end
`else
  localparam int unused_period = UPDATE_PERIOD;
  assign tick = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) acc[i] <= '0;
      flag <= '0;
      idx <= '0;
      m_axis_stat_tvalid <= 1'b0;
      m_axis_stat_tdata <= '0;
      m_axis_stat_tid <= '0;
    end else begin
      // a flushed channel restarts from this cycle's increment so nothing is lost
      for (int i = 0; i < COUNT; i++) begin
        acc[i] <= free && elig && idx == IW'(i) ? inc[i] : sum[i];
        flag[i] <= flush || (flag[i] && !(free && idx == IW'(i)));
      end
      if (free) begin
        idx <= idx == IW'(COUNT - 1) ? '0 : idx + IW'(1);
        m_axis_stat_tvalid <= elig;
        if (elig) begin
          m_axis_stat_tdata <= cur;
          m_axis_stat_tid <= STAT_ID_WIDTH'(ID_BASE) + STAT_ID_WIDTH'(idx);
        end
      end
    end
  end
endmodule

// File: tb/tb_stats_collect.sv
// tb_stats_collect: directed and randomized checks of stats_collect against a cycle-level behavioural model.
module tb_stats_collect;
  logic clk = 0, rst = 0, update = 0, tready = 1;
  logic [31:0] stat_inc = '0;
  logic [3:0] stat_valid = '0;
  logic [15:0] tdata;
  logic [7:0] tid;
  logic tvalid;
  int vectors = 0, miscompares = 0;
  int m_acc [4];
  bit m_flag [4];
  int m_idx = 0, m_timer = 0, m_data = 0, m_tid = 0;
  bit m_v = 0;
  logic [23:0] obs [$];
  logic [23:0] exp_q [$];

  stats_collect #(.COUNT(4), .INC_WIDTH(8), .ID_BASE(8), .UPDATE_PERIOD(64), .STAT_INC_WIDTH(16), .STAT_ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid), .update(update),
    .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid), .m_axis_stat_tvalid(tvalid), .m_axis_stat_tready(tready));

  always #5 clk = ~clk;

  function automatic bit m_elig(int i);
    return m_acc[i] != 0 && (m_acc[i] >= 32768 || m_flag[i]);
  endfunction

  task automatic tick();
    int n_acc [4];
    int add;
    bit fr, e, fl;
    if (tvalid === 1'b1 && tready) obs.push_back({tid, tdata});
    if (m_v && tready) exp_q.push_back({8'(m_tid), 16'(m_data)});
    fr = !m_v || tready;
    e = m_elig(m_idx);
`ifdef STATS_COLLECT_UPDATE_TIMER_EN
    fl = update || m_timer == 63;
`else
    fl = update;
`endif
    for (int i = 0; i < 4; i++) begin
      add = stat_valid[i] ? int'(stat_inc[i*8 +: 8]) : 0;
      n_acc[i] = (fr && e && i == m_idx) ? add : (m_acc[i] + add > 65535 ? 65535 : m_acc[i] + add);
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_flag[i] = 0; end
      m_idx = 0; m_timer = 0; m_v = 0; m_data = 0; m_tid = 0;
    end else begin
      if (fr) begin
        m_flag[m_idx] = 0;
        m_v = e;
        if (e) begin m_data = m_acc[m_idx]; m_tid = 8 + m_idx; end
        m_idx = (m_idx + 1) % 4;
      end
      if (fl) for (int i = 0; i < 4; i++) m_flag[i] = 1;
      for (int i = 0; i < 4; i++) m_acc[i] = n_acc[i];
      m_timer = (m_timer + 1) % 64;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stat_valid = '0; stat_inc = '0; update = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_in(); tready = 1;
    tick();
    rst = 0;
    obs.delete(); exp_q.delete();
  endtask

  task automatic run_until(int n, int budget);
    for (int k = 0; k < budget && obs.size() < n; k++) tick();
  endtask

  task automatic wait_valid(int budget);
    for (int k = 0; k < budget && tvalid !== 1'b1; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1; stat_valid = '1; stat_inc = '1; update = 1; tready = 1;
    tick(); tick();
    vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    vectors++; if (tdata !== 16'd0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0000", tdata); end
    vectors++; if (tid !== 8'd0) begin miscompares++; $display("FAIL reset_tid: got %h want 00", tid); end
    rst = 0; clear_in(); obs.delete(); exp_q.delete();
    update = 1; tick(); update = 0;
    repeat (10) tick();
    vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL reset_zero_channels: got %0d beats want 0", obs.size()); end
  endtask

  task automatic test_flush_single();
    int k;
    do_reset();
    stat_valid = 4'b0100; stat_inc[23:16] = 8'd5;
    repeat (3) tick();
    clear_in(); update = 1; tick(); update = 0;
    k = 0;
    while (tvalid !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (k < 1 || k > 5) begin miscompares++; $display("FAIL flush_latency: got %0d cycles want 1..5", k); end
    repeat (10) tick();
    vectors++; if (obs.size() != 1) begin miscompares++; $display("FAIL flush_beats: got %0d want 1", obs.size()); end
    vectors++; if (obs.size() > 0 && obs[0] !== {8'd10, 16'd15}) begin miscompares++; $display("FAIL flush_beat: got %h want 0a000f", obs[0]); end
  endtask

  task automatic test_threshold();
    int total;
    bit tid_ok;
    do_reset();
    stat_valid = 4'b0001; stat_inc[7:0] = 8'd255;
    repeat (200) tick();
    clear_in(); update = 1; tick(); update = 0;
    repeat (12) tick();
    total = 0; tid_ok = 1;
    foreach (obs[i]) begin total += int'(obs[i][15:0]); if (obs[i][23:16] != 8'd8) tid_ok = 0; end
    vectors++; if (total != 51000) begin miscompares++; $display("FAIL threshold_conservation: got %0d want 51000", total); end
    vectors++; if (obs.size() < 2 || !tid_ok) begin miscompares++; $display("FAIL threshold_beats: got %0d beats tid_ok=%0d want >=2 all tid 8", obs.size(), tid_ok); end
`ifndef STATS_COLLECT_UPDATE_TIMER_EN
    vectors++; if (obs.size() > 0 && obs[0][15:0] < 16'h8000) begin miscompares++; $display("FAIL threshold_first: got %h want >=8000", obs[0][15:0]); end
`endif
    vectors++; if (obs != exp_q) begin miscompares++; $display("FAIL threshold_model: got %0d beats want %0d", obs.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    stat_valid = 4'b0010; stat_inc[15:8] = 8'd1; tick(); clear_in();
    tready = 0; update = 1; tick(); update = 0;
    wait_valid(10);
    stat_valid = 4'b1101; stat_inc = 32'h01010001; update = 1;
    for (int k = 0; k < 20; k++) begin
      vectors++; if ({tvalid, tid, tdata} !== {1'b1, 8'd9, 16'd1}) begin miscompares++; $display("FAIL stall_hold: got %b/%h/%h want 1/09/0001", tvalid, tid, tdata); end
      tick(); clear_in();
    end
    tready = 1;
    run_until(4, 20);
    vectors++; if (obs.size() != 4) begin miscompares++; $display("FAIL stall_beats: got %0d want 4", obs.size()); end
    vectors++; if (obs.size() == 4 && {obs[0][23:16], obs[1][23:16], obs[2][23:16], obs[3][23:16]} !== 32'h090a0b08) begin miscompares++; $display("FAIL stall_order: got %h %h %h %h want 09 0a 0b 08", obs[0][23:16], obs[1][23:16], obs[2][23:16], obs[3][23:16]); end
  endtask

  task automatic test_saturation();
    do_reset();
    stat_valid = 4'b0010; stat_inc[15:8] = 8'd1; tick(); clear_in();
    tready = 0; update = 1; tick(); update = 0;
    wait_valid(10);
    stat_valid = 4'b0001; stat_inc[7:0] = 8'd255;
    repeat (300) tick();
    clear_in(); tready = 1;
    run_until(2, 10);
    vectors++; if (obs.size() < 2 || obs[1] !== {8'd8, 16'hffff}) begin miscompares++; $display("FAIL saturation: got %0d beats last %h want 08ffff", obs.size(), obs.size() > 1 ? obs[1] : 24'h0); end
  endtask

  task automatic test_same_cycle();
    bit hit;
    do_reset();
    stat_valid = 4'b0010; stat_inc[15:8] = 8'd7; tick(); clear_in();
    update = 1; tick(); update = 0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if ((!m_v || tready) && m_idx == 1 && m_elig(1)) begin stat_valid = 4'b0010; stat_inc[15:8] = 8'd3; hit = 1; end
      tick(); clear_in();
    end
    run_until(1, 10);
    repeat (5) tick();
    vectors++; if (obs.size() != 1 || obs[0] !== {8'd9, 16'd7}) begin miscompares++; $display("FAIL same_cycle_first: got %0d beats %h want 1 beat 090007", obs.size(), obs.size() > 0 ? obs[0] : 24'h0); end
    update = 1; tick(); update = 0;
    run_until(2, 10);
    vectors++; if (obs.size() != 2 || obs[1] !== {8'd9, 16'd3}) begin miscompares++; $display("FAIL same_cycle_second: got %0d beats %h want 090003", obs.size(), obs.size() > 1 ? obs[1] : 24'h0); end
  endtask

  task automatic test_timer();
    logic [3:0] seen;
    bit data_ok;
    do_reset();
    stat_valid = '1; stat_inc = 32'h01010101; tick(); clear_in();
`ifdef STATS_COLLECT_UPDATE_TIMER_EN
    run_until(4, 69);
    seen = '0; data_ok = 1;
    foreach (obs[i]) begin seen[obs[i][17:16]] = 1'b1; if (obs[i][15:0] != 16'd1 || obs[i][23:18] != 6'd2) data_ok = 0; end
    vectors++; if (obs.size() != 4 || seen != 4'hf || !data_ok) begin miscompares++; $display("FAIL timer_flush: got %0d beats seen %h data_ok %0d want 4 beats tid 8..11 data 1", obs.size(), seen, data_ok); end
`else
    repeat (200) tick();
    seen = '0; data_ok = 1;
    vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL no_timer: got %0d beats want 0", obs.size()); end
`endif
  endtask

  task automatic test_reset_inflight();
    do_reset();
    stat_valid = '1; stat_inc = 32'h05050505; tick(); clear_in();
    tready = 0; update = 1; tick(); update = 0;
    wait_valid(10);
    vectors++; if (tvalid !== 1'b1) begin miscompares++; $display("FAIL inflight_setup: got tvalid %b want 1", tvalid); end
    rst = 1; stat_valid = '1; stat_inc = '1; tick(); rst = 0; clear_in();
    vectors++; if ({tvalid, tid, tdata} !== 25'd0) begin miscompares++; $display("FAIL inflight_reset: got %b/%h/%h want 0/00/0000", tvalid, tid, tdata); end
    obs.delete();
    tready = 1; update = 1; tick(); update = 0;
    repeat (10) tick();
    vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL inflight_after: got %0d beats want 0", obs.size()); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      stat_valid = 4'($urandom);
      stat_inc = $urandom;
      update = $urandom_range(0, 19) == 0;
      tready = (c % 600) < 450 ? $urandom_range(0, 3) != 0 : 1'b0;
      tick();
      vectors++;
      if ({tvalid, tid, tdata} !== {m_v, 8'(m_tid), 16'(m_data)}) begin
        miscompares++;
        if (bad++ < 10) $display("FAIL random_cycle %0d: got %b/%h/%h want %b/%h/%h", c, tvalid, tid, tdata, m_v, 8'(m_tid), 16'(m_data));
      end
    end
    clear_in(); tready = 1;
    repeat (8) tick();
    vectors++; if (obs != exp_q || obs.size() == 0) begin miscompares++; $display("FAIL random_beats: got %0d beats want %0d", obs.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_flush_single();
    test_threshold();
    test_backpressure();
    test_saturation();
    test_same_cycle();
    test_timer();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
